// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter for the single data-memory port.
// Master 0 is the CPU load/store adapter, master 1 the DMA/copy engine. The winning
// request is registered onto the slave port. Read data returns in issue order through
// a {valid, owner} shift register that is READ_LATENCY stages deep.
// Optional feature: define DMEM_ARB_LOCK_EN to let a locking owner hold priority for up
// to MAX_BURST consecutive grants. Without it the mN_lock inputs are ignored.
module dmem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned READ_LATENCY = 1,   // legal range 1..4
    parameter int unsigned MAX_BURST    = 8    // >= 1
) (
    input  logic                  clock,
    input  logic                  reset,
    // master 0
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [2:0]            m0_op,
    input  logic                  m0_lock,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    // master 1
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [2:0]            m1_op,
    input  logic                  m1_lock,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    // slave port
    output logic                  s_re,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [2:0]            s_op,
    input  logic [DATA_WIDTH-1:0] s_rdata
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                  state_q, state_d;
    logic                    re_q, re_d;
    logic                    we_q, we_d;
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [2:0]              op_q, op_d;
    // Master granted most recently; during a strobe cycle it is the issuing master.
    logic                    last_owner_q, last_owner_d;
    logic [READ_LATENCY-1:0] pipe_vld_q;
    logic [READ_LATENCY-1:0] pipe_own_q;

    logic                    win_valid;
    logic                    win_id;
    logic                    tail_vld;
    logic                    tail_own;

`ifdef DMEM_ARB_LOCK_EN
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic            owner_hold;
    logic            owner_lock;
    logic            win_lock;

    // Winner selection: a locking owner keeps priority until its burst budget is spent.
    always_comb begin
        owner_lock = last_owner_q ? m1_lock : m0_lock;
        owner_hold = owner_lock && (last_owner_q ? m1_req : m0_req) &&
                     (burst_cnt_q < CntW'(MAX_BURST));
        win_valid  = m0_req | m1_req;
        if (m0_req && m1_req) begin
            win_id = owner_hold ? last_owner_q : ~last_owner_q;
        end else begin
            win_id = m1_req;
        end
        win_lock = win_id ? m1_lock : m0_lock;
    end

    // Burst counter: counts locked grants of the current owner, saturating at MAX_BURST.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (win_valid) begin
            if (!win_lock) begin
                burst_cnt_d = '0;
            end else if (win_id == last_owner_q) begin
                if (burst_cnt_q != CntW'(MAX_BURST)) begin
                    burst_cnt_d = burst_cnt_q + CntW'(1);
                end
            end else begin
                burst_cnt_d = CntW'(1);
            end
        end else if (!owner_lock) begin
            burst_cnt_d = '0;
        end
    end

    // Burst counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;

    // Winner selection: pure round-robin, the master that did not win last time goes first.
    always_comb begin
        win_valid = m0_req | m1_req;
        if (m0_req && m1_req) begin
            win_id = ~last_owner_q;
        end else begin
            win_id = m1_req;
        end
    end
`endif

    // Issue FSM and next-state of the registered slave payload and grant pulses.
    always_comb begin
        state_d      = state_q;
        re_d         = 1'b0;
        we_d         = 1'b0;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_d         = op_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StIdle: begin
                if (win_valid) state_d = StIssue;
            end
            StIssue: begin
                if (!win_valid) begin
                    state_d = StIdle;
                    re_d    = 1'b0;
                    we_d    = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (win_valid) begin
            last_owner_d = win_id;
            gnt0_d       = ~win_id;
            gnt1_d       = win_id;
            we_d         = win_id ? m1_we : m0_we;
            re_d         = ~we_d;
            addr_d       = win_id ? m1_addr  : m0_addr;
            wdata_d      = win_id ? m1_wdata : m0_wdata;
            op_d         = win_id ? m1_op    : m0_op;
        end
    end

    // Slave-side registers, grant pulses and arbitration history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            re_q         <= 1'b0;
            we_q         <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_q         <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            re_q         <= re_d;
            we_q         <= we_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_q         <= op_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Read-return pipe: stage 0 captures the strobe cycle, the tail lines up with s_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe_vld_q <= '0;
            pipe_own_q <= '0;
        end else begin
            pipe_vld_q[0] <= re_q;
            pipe_own_q[0] <= last_owner_q;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_own_q[i] <= pipe_own_q[i-1];
            end
        end
    end

    assign tail_vld  = pipe_vld_q[READ_LATENCY-1];
    assign tail_own  = pipe_own_q[READ_LATENCY-1];

    assign m0_rvalid = tail_vld & ~tail_own;
    assign m1_rvalid = tail_vld &  tail_own;
    assign m0_rdata  = m0_rvalid ? s_rdata : '0;
    assign m1_rdata  = m1_rvalid ? s_rdata : '0;

    assign m0_gnt    = gnt0_q;
    assign m1_gnt    = gnt1_q;
    assign s_re      = re_q;
    assign s_we      = we_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_op      = op_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter. Two instances share the master
// stimulus: dut_a with READ_LATENCY=1, dut_b with READ_LATENCY=3. Each has its own
// slave read model over one shared word memory (initial word at a = 0xC0DE0000 | a).
module tb_dmem_arbiter;

    localparam logic       Y  = 1'b1;
    localparam logic       N  = 1'b0;
    localparam logic [1:0] GN = 2'b00;  // no grant
    localparam logic [1:0] G0 = 2'b01;  // m0 granted
    localparam logic [1:0] G1 = 2'b10;  // m1 granted
    localparam logic [1:0] NS = 2'b00;  // no strobe
    localparam logic [1:0] RD = 2'b01;  // s_re
    localparam logic [1:0] WR = 2'b10;  // s_we
    localparam logic [1:0] NO = 2'd0;   // no read return
    localparam logic [1:0] M0 = 2'd1;   // return to m0
    localparam logic [1:0] M1 = 2'd2;   // return to m1
    localparam logic [2:0] OP0 = 3'd1;
    localparam logic [2:0] OP1 = 3'd2;  // "word" for master 1

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_op, m1_op;

    logic        m0_gnt_a, m0_rvalid_a, m1_gnt_a, m1_rvalid_a, s_re_a, s_we_a;
    logic [31:0] m0_rdata_a, m1_rdata_a, s_addr_a, s_wdata_a, rdata_a;
    logic [2:0]  s_op_a;
    logic        m0_gnt_b, m0_rvalid_b, m1_gnt_b, m1_rvalid_b, s_re_b, s_we_b;
    logic [31:0] m0_rdata_b, m1_rdata_b, s_addr_b, s_wdata_b, rb0, rb1, rb2;
    logic [2:0]  s_op_b;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          row      = 0;
    string       tname    = "reset";

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1), .MAX_BURST(4)) dut_a (
        .clock(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_op(m0_op), .m0_lock(m0_lock), .m0_gnt(m0_gnt_a), .m0_rvalid(m0_rvalid_a),
        .m0_rdata(m0_rdata_a),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_op(m1_op), .m1_lock(m1_lock), .m1_gnt(m1_gnt_a), .m1_rvalid(m1_rvalid_a),
        .m1_rdata(m1_rdata_a),
        .s_re(s_re_a), .s_we(s_we_a), .s_addr(s_addr_a), .s_wdata(s_wdata_a), .s_op(s_op_a),
        .s_rdata(rdata_a)
    );

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3), .MAX_BURST(4)) dut_b (
        .clock(clk), .reset(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_op(m0_op), .m0_lock(m0_lock), .m0_gnt(m0_gnt_b), .m0_rvalid(m0_rvalid_b),
        .m0_rdata(m0_rdata_b),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_op(m1_op), .m1_lock(m1_lock), .m1_gnt(m1_gnt_b), .m1_rvalid(m1_rvalid_b),
        .m1_rdata(m1_rdata_b),
        .s_re(s_re_b), .s_we(s_we_b), .s_addr(s_addr_b), .s_wdata(s_wdata_b), .s_op(s_op_b),
        .s_rdata(rb2)
    );

    // Shared memory: initialised on reset, written by dut_a's write strobe.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | (i << 2);
        end else if (s_we_a) begin
            mem[s_addr_a[9:2]] <= s_wdata_a;
        end
    end

    // Slave read models; non-read cycles return junk that the DUT must mask.
    always @(posedge clk) begin
        rdata_a <= s_re_a ? mem[s_addr_a[9:2]] : 32'h5A5A_5A5A;
        rb0     <= s_re_b ? mem[s_addr_b[9:2]] : 32'h5A5A_5A5A;
        rb1     <= rb0;
        rb2     <= rb1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Apply one row of master inputs, clock once, then compare both instances.
    task automatic step(input logic r0, w0, input logic [31:0] a0, d0,
                        input logic r1, w1, input logic [31:0] a1, d1,
                        input logic [1:0] eg, es, input logic [31:0] ea,
                        input logic [1:0] ra, input logic [31:0] da,
                        input logic [1:0] rb, input logic [31:0] db);
        string t;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        @(negedge clk);
        row++;
        t = $sformatf("%s.r%0d", tname, row);
        check({t, ".gnt_a"}, 32'({m1_gnt_a, m0_gnt_a}), 32'(eg));
        check({t, ".gnt_b"}, 32'({m1_gnt_b, m0_gnt_b}), 32'(eg));
        check({t, ".strobe_a"}, 32'({s_we_a, s_re_a}), 32'(es));
        check({t, ".strobe_b"}, 32'({s_we_b, s_re_b}), 32'(es));
        check({t, ".addr_a"}, s_addr_a, ea);
        check({t, ".addr_b"}, s_addr_b, ea);
        if (eg != GN) check({t, ".op_a"}, 32'(s_op_a), 32'(eg[1] ? OP1 : OP0));
        if (es[1]) check({t, ".wdata_a"}, s_wdata_a, eg[1] ? d1 : d0);
        check({t, ".rv_a"}, 32'({m1_rvalid_a, m0_rvalid_a}), 32'(ra));
        check({t, ".rd0_a"}, m0_rdata_a, (ra == M0) ? da : 32'h0);
        check({t, ".rd1_a"}, m1_rdata_a, (ra == M1) ? da : 32'h0);
        check({t, ".rv_b"}, 32'({m1_rvalid_b, m0_rvalid_b}), 32'(rb));
        check({t, ".rd0_b"}, m0_rdata_b, (rb == M0) ? db : 32'h0);
        check({t, ".rd1_b"}, m1_rdata_b, (rb == M1) ? db : 32'h0);
    endtask

    task automatic idle(input logic [31:0] ea, input logic [1:0] ra, input logic [31:0] da,
                        input logic [1:0] rb, input logic [31:0] db);
        step(N, N, 32'h0, 32'h0, N, N, 32'h0, 32'h0, GN, NS, ea, ra, da, rb, db);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        m0_req = N; m0_we = N; m0_addr = '0; m0_wdata = '0; m0_op = OP0; m0_lock = N;
        m1_req = N; m1_we = N; m1_addr = '0; m1_wdata = '0; m1_op = OP1; m1_lock = N;
        repeat (2) @(negedge clk);
        check("rst.gnt", 32'({m1_gnt_a, m0_gnt_a, m1_gnt_b, m0_gnt_b}), 32'h0);
        check("rst.strobe", 32'({s_we_a, s_re_a, s_we_b, s_re_b}), 32'h0);
        check("rst.addr", s_addr_a | s_addr_b | s_wdata_a | 32'(s_op_a), 32'h0);
        check("rst.rvalid", 32'({m1_rvalid_a, m0_rvalid_a, m1_rvalid_b, m0_rvalid_b}), 32'h0);
        rst = 1'b0;

        // Reset while an m0 read is in flight: no return may appear afterwards.
        tname = "t1";
        m0_req = Y; m0_addr = 32'h40;
        @(negedge clk);
        check("t1.gnt", 32'({m1_gnt_a, m0_gnt_a}), 32'(G0));
        check("t1.re", 32'({s_we_a, s_re_a}), 32'(RD));
        m0_req = N;
        rst = 1'b1;
        #1;
        check("t1.rst_out_a", 32'({m0_gnt_a, s_re_a, s_we_a, m0_rvalid_a}) | s_addr_a, 32'h0);
        check("t1.rst_out_b", 32'({m0_gnt_b, s_re_b, s_we_b, m0_rvalid_b}) | s_addr_b, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("t1.norv%0d", i),
                  32'({m0_rvalid_a, m0_rvalid_b}) | m0_rdata_a | m0_rdata_b, 32'h0);
        end

        // m0 alone, back-to-back reads.
        tname = "t2"; row = 0;
        step(Y, N, 32'h100, 0, N, N, 0, 0, G0, RD, 32'h100, NO, 0, NO, 0);
        step(Y, N, 32'h104, 0, N, N, 0, 0, G0, RD, 32'h104, M0, 32'hC0DE0100, NO, 0);
        step(Y, N, 32'h108, 0, N, N, 0, 0, G0, RD, 32'h108, M0, 32'hC0DE0104, NO, 0);
        idle(32'h108, M0, 32'hC0DE0108, M0, 32'hC0DE0100);
        idle(32'h108, NO, 0, M0, 32'hC0DE0104);
        idle(32'h108, NO, 0, M0, 32'hC0DE0108);
        idle(32'h108, NO, 0, NO, 0);

        // Both masters from reset: m0 first, then strict alternation.
        tname = "t3"; row = 0;
        do_reset();
        step(Y, N, 32'h10, 0, Y, N, 32'h20, 0, G0, RD, 32'h10, NO, 0, NO, 0);
        step(Y, N, 32'h14, 0, Y, N, 32'h20, 0, G1, RD, 32'h20, M0, 32'hC0DE0010, NO, 0);
        step(Y, N, 32'h14, 0, Y, N, 32'h24, 0, G0, RD, 32'h14, M1, 32'hC0DE0020, NO, 0);
        step(N, N, 0, 0, Y, N, 32'h24, 0, G1, RD, 32'h24, M0, 32'hC0DE0014,
             M0, 32'hC0DE0010);
        idle(32'h24, M1, 32'hC0DE0024, M1, 32'hC0DE0020);
        idle(32'h24, NO, 0, M0, 32'hC0DE0014);
        idle(32'h24, NO, 0, M1, 32'hC0DE0024);
        idle(32'h24, NO, 0, NO, 0);

        // m1 writes, m0 reads the same word back.
        tname = "t4"; row = 0;
        step(N, N, 0, 0, Y, Y, 32'h200, 32'hDEADBEEF, G1, WR, 32'h200, NO, 0, NO, 0);
        step(Y, N, 32'h200, 0, N, N, 0, 0, G0, RD, 32'h200, NO, 0, NO, 0);
        idle(32'h200, M0, 32'hDEADBEEF, NO, 0);
        idle(32'h200, NO, 0, NO, 0);
        idle(32'h200, NO, 0, M0, 32'hDEADBEEF);
        idle(32'h200, NO, 0, NO, 0);

        // Mixed reads and writes from both masters; writes never return.
        tname = "t5"; row = 0;
        step(Y, Y, 32'h300, 32'h11111111, Y, N, 32'h120, 0, G1, RD, 32'h120, NO, 0, NO, 0);
        step(Y, Y, 32'h300, 32'h11111111, Y, Y, 32'h124, 32'h22222222, G0, WR, 32'h300,
             M1, 32'hC0DE0120, NO, 0);
        step(Y, N, 32'h300, 0, Y, Y, 32'h124, 32'h22222222, G1, WR, 32'h124, NO, 0, NO, 0);
        step(Y, N, 32'h300, 0, Y, N, 32'h124, 0, G0, RD, 32'h300, NO, 0, M1, 32'hC0DE0120);
        step(N, N, 0, 0, Y, N, 32'h124, 0, G1, RD, 32'h124, M0, 32'h11111111, NO, 0);
        idle(32'h124, M1, 32'h22222222, NO, 0);
        idle(32'h124, NO, 0, M0, 32'h11111111);
        idle(32'h124, NO, 0, M1, 32'h22222222);
        idle(32'h124, NO, 0, NO, 0);

`ifdef DMEM_ARB_LOCK_EN
        // m1 locks: four grants, one forced rotation to m0, four again.
        tname = "t6"; row = 0;
        m1_lock = Y;
        do_reset();
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, NO, 0, NO, 0);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M1, 32'hC0DE0050, NO, 0);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M1, 32'hC0DE0050, NO, 0);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M1, 32'hC0DE0050,
             M1, 32'hC0DE0050);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G0, RD, 32'h40, M1, 32'hC0DE0050,
             M1, 32'hC0DE0050);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M0, 32'hC0DE0040,
             M1, 32'hC0DE0050);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M1, 32'hC0DE0050,
             M1, 32'hC0DE0050);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M1, 32'hC0DE0050,
             M0, 32'hC0DE0040);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M1, 32'hC0DE0050,
             M1, 32'hC0DE0050);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G0, RD, 32'h40, M1, 32'hC0DE0050,
             M1, 32'hC0DE0050);
        idle(32'h40, M0, 32'hC0DE0040, M1, 32'hC0DE0050);
        idle(32'h40, NO, 0, M1, 32'hC0DE0050);
        idle(32'h40, NO, 0, M0, 32'hC0DE0040);
        idle(32'h40, NO, 0, NO, 0);
        m1_lock = N;
`else
        // Lock inputs have no effect: plain alternation from reset.
        tname = "t6"; row = 0;
        m0_lock = Y; m1_lock = Y;
        do_reset();
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G0, RD, 32'h40, NO, 0, NO, 0);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M0, 32'hC0DE0040, NO, 0);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G0, RD, 32'h40, M1, 32'hC0DE0050, NO, 0);
        step(Y, N, 32'h40, 0, Y, N, 32'h50, 0, G1, RD, 32'h50, M0, 32'hC0DE0040,
             M0, 32'hC0DE0040);
        idle(32'h50, M1, 32'hC0DE0050, M1, 32'hC0DE0050);
        idle(32'h50, NO, 0, M0, 32'hC0DE0040);
        idle(32'h50, NO, 0, M1, 32'hC0DE0050);
        idle(32'h50, NO, 0, NO, 0);
        m0_lock = N; m1_lock = N;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
